// File: rtl/writeback_rf.sv
// writeback_rf
//   Writeback stage with an integrated register file. Accepts one result per
//   valid/ready transfer, commits it to the register file in a dedicated
//   COMMIT cycle, then pulses done for one cycle. Two combinational read ports.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   : during COMMIT, read ports addressing the pending dst see the
//                 pending val (when the pending op writes and dst is in range)
//     undefined : read ports return register contents only
//
//   Ports
//     clk        in   sole clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   execute presents a result
//     in_ready   out  block can accept (state == IDLE)
//     op         in   opcode of presented result
//     dst        in   destination register index
//     val        in   result value
//     rd_addr_a  in   read port A address
//     rd_data_a  out  read port A data (combinational)
//     rd_addr_b  in   read port B address
//     rd_data_b  out  read port B data (combinational)
//     done       out  one-cycle pulse per completed commit
//     err        out  sticky: a write to an out-of-range dst was committed
//     retired    out  count of completed commits, wraps
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | ready for a result; in_ready = 1
//   COMMIT | pending result is written on the next edge
module writeback_rf #(
  parameter int         WIDTH  = 8,
  parameter int         NREGS  = 4,
  parameter logic [1:0] OP_LOD = 2'b01,
  parameter logic [1:0] OP_ADD = 2'b11,
  localparam int        AW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] val,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             done,
  output logic             err,
  output logic [15:0]      retired
);

  // One extra bit so NREGS itself is representable for range compares.
  localparam logic [AW:0] LP_NREGS = (AW+1)'(NREGS);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_COMMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_pend_op;
  logic [AW-1:0]    r_pend_dst;
  logic [WIDTH-1:0] r_pend_val;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_done;
  logic             r_err;
  logic [15:0]      r_retired;

  logic             w_in_ready;
  logic             w_commit;
  logic             w_xfer;
  logic             w_pend_writes;
  logic             w_pend_in_range;
  logic             w_wr_en;
  logic             w_wr_drop;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_in_ready = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE:   w_in_ready = 1'b1;
      S_COMMIT: w_commit   = 1'b1;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_xfer          = in_valid && w_in_ready;
  assign w_pend_writes   = (r_pend_op == OP_LOD) || (r_pend_op == OP_ADD);
  assign w_pend_in_range = ({1'b0, r_pend_dst} < LP_NREGS);
  assign w_wr_en         = w_commit && w_pend_writes && w_pend_in_range;
  assign w_wr_drop       = w_commit && w_pend_writes && !w_pend_in_range;

  // ---------------- pending register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_op  <= '0;
      r_pend_dst <= '0;
      r_pend_val <= '0;
    end else if (w_xfer) begin
      r_pend_op  <= op;
      r_pend_dst <= dst;
      r_pend_val <= val;
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_en && (r_pend_dst == AW'(i))) r_regs[i] <= r_pend_val;
      end
    end
  end

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_done <= w_commit;
      if (w_wr_drop) r_err <= 1'b1;
      if (w_commit)  r_retired <= r_retired + 16'd1;
    end
  end

  // ---------------- read ports ----------------
  always_comb begin
    w_rd_a = '0;
    if ({1'b0, rd_addr_a} < LP_NREGS) begin
      w_rd_a = r_regs[rd_addr_a];
`ifdef WB_BYPASS_EN
      // w_wr_en already implies COMMIT, a writing op and an in-range dst.
      if (w_wr_en && (r_pend_dst == rd_addr_a)) w_rd_a = r_pend_val;
`endif
    end
  end

  always_comb begin
    w_rd_b = '0;
    if ({1'b0, rd_addr_b} < LP_NREGS) begin
      w_rd_b = r_regs[rd_addr_b];
`ifdef WB_BYPASS_EN
      if (w_wr_en && (r_pend_dst == rd_addr_b)) w_rd_b = r_pend_val;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign rd_data_a = w_rd_a;
  assign rd_data_b = w_rd_b;
  assign done      = r_done;
  assign err       = r_err;
  assign retired   = r_retired;

endmodule

// File: tb/tb_writeback_rf.sv
module tb_writeback_rf;

  logic clk;
  logic rst_n;

  // DUT A: NREGS = 4, DUT B: NREGS = 3 (both AW = 2)
  logic       a_in_valid, a_in_ready, a_done, a_err;
  logic [1:0] a_op, a_dst, a_rd_addr_a, a_rd_addr_b;
  logic [7:0] a_val, a_rd_data_a, a_rd_data_b;
  logic [15:0] a_retired;

  logic       b_in_valid, b_in_ready, b_done, b_err;
  logic [1:0] b_op, b_dst, b_rd_addr_a, b_rd_addr_b;
  logic [7:0] b_val, b_rd_data_a, b_rd_data_b;
  logic [15:0] b_retired;

  writeback_rf #(.WIDTH(8), .NREGS(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op(a_op), .dst(a_dst), .val(a_val),
    .rd_addr_a(a_rd_addr_a), .rd_data_a(a_rd_data_a),
    .rd_addr_b(a_rd_addr_b), .rd_data_b(a_rd_data_b),
    .done(a_done), .err(a_err), .retired(a_retired)
  );

  writeback_rf #(.WIDTH(8), .NREGS(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op(b_op), .dst(b_dst), .val(b_val),
    .rd_addr_a(b_rd_addr_a), .rd_data_a(b_rd_data_a),
    .rd_addr_b(b_rd_addr_b), .rd_data_b(b_rd_data_b),
    .done(b_done), .err(b_err), .retired(b_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ret;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done cycle pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && a_done) begin
        if (q_a.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q_a.pop_front();
          chk("a_retired", {16'd0, a_retired}, {16'd0, e.ret});
          chk("a_err", {31'd0, a_err}, {31'd0, e.err});
        end
      end
      if (rst_n && b_done) begin
        if (q_b.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q_b.pop_front();
          chk("b_retired", {16'd0, b_retired}, {16'd0, e.ret});
          chk("b_err", {31'd0, b_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Issue one transfer; returns 1 ns after the transfer edge (cycle k..k+1).
  task automatic send(input bit sel_b, input logic [1:0] op, input logic [1:0] dst,
                      input logic [7:0] val, input bit push,
                      input logic [15:0] exp_ret, input logic exp_err);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (((sel_b ? b_in_ready : a_in_ready) !== 1'b1) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) chk("ready_timeout", 32'd1, 32'd0);
    if (sel_b) begin
      b_op = op; b_dst = dst; b_val = val; b_in_valid = 1'b1;
      if (push) q_b.push_back('{ret: exp_ret, err: exp_err});
    end else begin
      a_op = op; a_dst = dst; a_val = val; a_in_valid = 1'b1;
      if (push) q_a.push_back('{ret: exp_ret, err: exp_err});
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] addr, input logic [7:0] exp, input string name);
    a_rd_addr_a = addr; a_rd_addr_b = addr;
    #1;
    chk({name, "_pa"}, {24'd0, a_rd_data_a}, {24'd0, exp});
    chk({name, "_pb"}, {24'd0, a_rd_data_b}, {24'd0, exp});
  endtask

  task automatic rd_b(input logic [1:0] addr, input logic [7:0] exp, input string name);
    b_rd_addr_a = addr; b_rd_addr_b = addr;
    #1;
    chk({name, "_pa"}, {24'd0, b_rd_data_a}, {24'd0, exp});
    chk({name, "_pb"}, {24'd0, b_rd_data_b}, {24'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_byp;
    rst_n = 1'b0;
    a_in_valid = 0; a_op = 0; a_dst = 0; a_val = 0; a_rd_addr_a = 0; a_rd_addr_b = 0;
    b_in_valid = 0; b_op = 0; b_dst = 0; b_val = 0; b_rd_addr_a = 0; b_rd_addr_b = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_retired", {16'd0, a_retired}, 32'd0);
    for (int i = 0; i < 4; i++) rd_a(2'(i), 8'h00, "rst_reg");

    // LOD dst=2 val=A5
    send(0, 2'b01, 2'd2, 8'hA5, 1, 16'd1, 1'b0);
    chk("t1_in_ready_commit", {31'd0, a_in_ready}, 32'd0);
    @(posedge clk); #1;
    rd_a(2'd2, 8'hA5, "t1_reg2");
    chk("t1_in_ready_back", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", {31'd0, a_done}, 32'd0);

    // Non-writing op to reg 1
    send(0, 2'b10, 2'd1, 8'h77, 1, 16'd2, 1'b0);
    @(posedge clk); #1;
    rd_a(2'd1, 8'h00, "t2_reg1");

    // ADD dst=3 val=3C, read during COMMIT
    send(0, 2'b11, 2'd3, 8'h3C, 1, 16'd3, 1'b0);
`ifdef WB_BYPASS_EN
    exp_byp = 8'h3C;
`else
    exp_byp = 8'h00;
`endif
    rd_a(2'd3, exp_byp, "t3_commit_read");
    @(posedge clk); #1;
    rd_a(2'd3, 8'h3C, "t3_reg3");

    // Back-to-back to same dst, second transfer coincides with done
    send(0, 2'b01, 2'd2, 8'h11, 1, 16'd4, 1'b0);
    send(0, 2'b11, 2'd2, 8'h22, 1, 16'd5, 1'b0);
    @(posedge clk); #1;
    rd_a(2'd2, 8'h22, "t4_reg2");
    rd_a(2'd3, 8'h3C, "t4_reg3");

    // NREGS=3: out-of-range dst
    send(1, 2'b01, 2'd3, 8'h5A, 1, 16'd1, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rd_b(2'(i), 8'h00, "t5_reg");
    send(1, 2'b01, 2'd0, 8'h12, 1, 16'd2, 1'b1);
    @(posedge clk); #1;
    rd_b(2'd0, 8'h12, "t5_reg0");
    rd_b(2'd3, 8'h00, "t5_oor_read");
    chk("t5_err_sticky", {31'd0, b_err}, 32'd1);

    // Reset in the middle of COMMIT: no write, no done
    repeat (2) @(posedge clk);
    chk("t6_queue_drained", q_a.size() + q_b.size(), 32'd0);
    send(0, 2'b01, 2'd0, 8'hFF, 0, 16'd0, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("t6_done_in_rst", {31'd0, a_done}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("t6_retired", {16'd0, a_retired}, 32'd0);
    chk("t6_b_err_cleared", {31'd0, b_err}, 32'd0);
    rd_a(2'd0, 8'h00, "t6_reg0");
    rd_a(2'd2, 8'h00, "t6_reg2");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_queue_empty", q_a.size() + q_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
